// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the MIPS hazard scoreboard:
//                forwarding-select encodings, default latency width and
//                stall-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Default width of the per-register latency countdown.
  localparam int LATW_DEF    = 3;

  // Width of the saturating stall-cycle counter.
  localparam int STALL_CNT_W = 32;

  // Operand source select for the execute stage.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,  // register file
    FWD_W  = 2'b01,  // writeback-stage result
    FWD_M  = 2'b10   // memory-stage result
  } fwd_sel_e;

endpackage
`default_nettype wire

// File: rtl/mips_hazard_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_hazard_sb_if
//  Description : Pipeline-control bundle between the decode/execute stages
//                and the hazard scoreboard.
//                slave  : scoreboard side (decode/E/M/W info in, stall and
//                         forwarding selects out)
//                master : pipeline side
//  Ports       : decode  - rs_d, rt_d, use_rs_d, use_rt_d, dst_d, wr_d,
//                          lat_d, valid_d
//                control - hold, flush_e
//                execute - rs_e, rt_e
//                M / W   - wreg_m, regwrite_m, wreg_w, regwrite_w
//                outputs - stall_d, fwd_a_e, fwd_b_e, stall_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_hazard_sb_if #(
  parameter int AW   = 5,
  parameter int LATW = mips_pkg::LATW_DEF
);
  import mips_pkg::*;

  logic [AW-1:0]          rs_d;
  logic [AW-1:0]          rt_d;
  logic                   use_rs_d;
  logic                   use_rt_d;
  logic [AW-1:0]          dst_d;
  logic                   wr_d;
  logic [LATW-1:0]        lat_d;
  logic                   valid_d;
  logic                   hold;
  logic                   flush_e;
  logic [AW-1:0]          rs_e;
  logic [AW-1:0]          rt_e;
  logic [AW-1:0]          wreg_m;
  logic                   regwrite_m;
  logic [AW-1:0]          wreg_w;
  logic                   regwrite_w;
  logic                   stall_d;
  logic [1:0]             fwd_a_e;
  logic [1:0]             fwd_b_e;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport slave (
    input  rs_d, rt_d, use_rs_d, use_rt_d, dst_d, wr_d, lat_d, valid_d,
    input  hold, flush_e, rs_e, rt_e,
    input  wreg_m, regwrite_m, wreg_w, regwrite_w,
    output stall_d, fwd_a_e, fwd_b_e, stall_cnt
  );

  modport master (
    output rs_d, rt_d, use_rs_d, use_rt_d, dst_d, wr_d, lat_d, valid_d,
    output hold, flush_e, rs_e, rt_e,
    output wreg_m, regwrite_m, wreg_w, regwrite_w,
    input  stall_d, fwd_a_e, fwd_b_e, stall_cnt
  );

endinterface
`default_nettype wire

// File: rtl/mips_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : mips_fwd_sel
//  Description : Forwarding select for one execute-stage source operand.
//                M-stage result wins over W-stage; register 0 never
//                forwards.
//  Ports       : i_rs         - execute-stage source index
//                i_wreg_m     - M-stage destination, i_regwrite_m its enable
//                i_wreg_w     - W-stage destination, i_regwrite_w its enable
//                o_fwd        - operand select (FWD_RF / FWD_W / FWD_M)
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_fwd_sel
  import mips_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] i_rs,
  input  logic [AW-1:0] i_wreg_m,
  input  logic          i_regwrite_m,
  input  logic [AW-1:0] i_wreg_w,
  input  logic          i_regwrite_w,
  output logic [1:0]    o_fwd
);

  logic w_hit_m;
  logic w_hit_w;

  assign w_hit_m = i_regwrite_m & (i_wreg_m != '0) & (i_wreg_m == i_rs);
  assign w_hit_w = i_regwrite_w & (i_wreg_w != '0) & (i_wreg_w == i_rs);

  always_comb begin
    o_fwd = FWD_RF;
    if (w_hit_m) begin
      o_fwd = FWD_M;
    end else if (w_hit_w) begin
      o_fwd = FWD_W;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_hazard_sb.sv
`default_nettype none
// ============================================================================
//  Module      : mips_hazard_sb
//  Description : Latency scoreboard hazard unit for an in-order MIPS pipe.
//                Each architectural register carries a countdown of cycles
//                until its pending result becomes forwardable; decode stalls
//                on RAW/WAW against busy registers. Also produces E-stage
//                forwarding selects and a saturating stall-cycle counter.
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous, active-low reset
//                bus   - mips_hazard_sb_if.slave pipeline-control bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_hazard_sb
  import mips_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int LATW = LATW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  mips_hazard_sb_if.slave  bus
);

  logic [NREG-1:0]        w_busy;
  logic                   w_stall;
  logic                   w_issue;
  logic                   w_load;
  logic                   w_flush_hit;
  logic                   r_last_vld;
  logic [AW-1:0]          r_last_dst;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Gating with reset keeps stall low while reset is held even though the
  // counts are already clear.
  assign w_stall = reset & bus.valid_d &
                   ((bus.use_rs_d & w_busy[bus.rs_d]) |
                    (bus.use_rt_d & w_busy[bus.rt_d]) |
                    (bus.wr_d     & w_busy[bus.dst_d]));

  assign w_issue = bus.valid_d & ~w_stall & ~bus.hold;

  // Only multi-cycle producers to a real register occupy the scoreboard;
  // ALU-class results are covered by plain forwarding.
  assign w_load  = w_issue & bus.wr_d & (bus.dst_d != '0) & (bus.lat_d != '0);

  // A flush only cancels something if the instruction now in E loaded an
  // entry when it issued last cycle.
  assign w_flush_hit = bus.flush_e & r_last_vld;

  // --------------------------------------------------------------------------
  // Per-register countdowns. Register 0 has no storage and is never busy.
  // Priority within a non-hold cycle: load, flush-clear, decrement.
  // A load cannot collide with the flush target: the flushed register is
  // still busy this cycle, so its WAW check blocks the issue.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_ent
      if (gi == 0) begin : g_zero
        assign w_busy[gi] = 1'b0;
      end else begin : g_cnt
        localparam logic [AW-1:0] c_idx = AW'(gi);
        logic [LATW-1:0] r_cnt;

        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            r_cnt <= '0;
          end else if (!bus.hold) begin
            if (w_load && (bus.dst_d == c_idx)) begin
              r_cnt <= bus.lat_d;
            end else if (w_flush_hit && (r_last_dst == c_idx)) begin
              r_cnt <= '0;
            end else if (r_cnt != '0) begin
              r_cnt <= r_cnt - LATW'(1);
            end
          end
        end

        assign w_busy[gi] = |r_cnt;
      end
    end
  endgenerate

  // Remember which entry the instruction now entering E loaded, so a flush
  // next cycle can release it. Frozen along with everything else on hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_vld <= 1'b0;
      r_last_dst <= '0;
    end else if (!bus.hold) begin
      r_last_vld <= w_load;
      if (w_load) begin
        r_last_dst <= bus.dst_d;
      end
    end
  end

  // Stall cycles are counted whether or not the pipe is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign bus.stall_d   = w_stall;
  assign bus.stall_cnt = r_stall_cnt;

  mips_fwd_sel #(.AW(AW)) u_fwd_a (
    .i_rs         (bus.rs_e),
    .i_wreg_m     (bus.wreg_m),
    .i_regwrite_m (bus.regwrite_m),
    .i_wreg_w     (bus.wreg_w),
    .i_regwrite_w (bus.regwrite_w),
    .o_fwd        (bus.fwd_a_e)
  );

  mips_fwd_sel #(.AW(AW)) u_fwd_b (
    .i_rs         (bus.rt_e),
    .i_wreg_m     (bus.wreg_m),
    .i_regwrite_m (bus.regwrite_m),
    .i_wreg_w     (bus.wreg_w),
    .i_regwrite_w (bus.regwrite_w),
    .o_fwd        (bus.fwd_b_e)
  );

endmodule
`default_nettype wire

// File: tb/tb_mips_hazard_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_hazard_sb
//  Description : Self-checking bench for mips_hazard_sb. A behavioural model
//                tracks remaining cycles per register as plain integers;
//                directed scenarios cover load-use, multicycle, hold, flush,
//                forwarding priority and reset, followed by random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_hazard_sb;
  import mips_pkg::*;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int LATW = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  mips_hazard_sb_if #(.AW(AW), .LATW(LATW)) bus ();

  mips_hazard_sb #(.NREG(NREG), .AW(AW), .LATW(LATW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int     n_vec = 0;
  int     n_bad = 0;
  int     m_cnt [NREG];
  bit     m_last_vld;
  int     m_last_dst;
  longint m_scnt;
  bit     obs_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_busy(int r);
    return (r != 0) && (m_cnt[r] > 0);
  endfunction

  function automatic int m_fwd(int src);
    if (bus.regwrite_m && int'(bus.wreg_m) != 0 && int'(bus.wreg_m) == src) return 2;
    if (bus.regwrite_w && int'(bus.wreg_w) != 0 && int'(bus.wreg_w) == src) return 1;
    return 0;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    m_last_vld = 1'b0;
    m_last_dst = 0;
    m_scnt     = 0;
  endtask

  task automatic idle();
    bus.rs_d = '0; bus.rt_d = '0; bus.use_rs_d = 1'b0; bus.use_rt_d = 1'b0;
    bus.dst_d = '0; bus.wr_d = 1'b0; bus.lat_d = '0; bus.valid_d = 1'b0;
    bus.hold = 1'b0; bus.flush_e = 1'b0;
    bus.rs_e = '0; bus.rt_e = '0;
    bus.wreg_m = '0; bus.regwrite_m = 1'b0;
    bus.wreg_w = '0; bus.regwrite_w = 1'b0;
  endtask

  // Called just after a falling edge with inputs applied; checks outputs,
  // advances the model across the next rising edge, returns at the next
  // falling edge.
  task automatic step();
    bit s;
    bit ld;
    #1;
    s = bus.valid_d &&
        ((bus.use_rs_d && m_busy(int'(bus.rs_d))) ||
         (bus.use_rt_d && m_busy(int'(bus.rt_d))) ||
         (bus.wr_d     && m_busy(int'(bus.dst_d))));
    chk("stall_d",   64'(bus.stall_d),   64'(s));
    chk("fwd_a_e",   64'(bus.fwd_a_e),   64'(m_fwd(int'(bus.rs_e))));
    chk("fwd_b_e",   64'(bus.fwd_b_e),   64'(m_fwd(int'(bus.rt_e))));
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_scnt));
    obs_stall = bus.stall_d;
    if (!bus.hold) begin
      ld = bus.valid_d && !s && bus.wr_d && bus.dst_d != 0 && bus.lat_d != 0;
      for (int r = 0; r < NREG; r++) if (m_cnt[r] > 0) m_cnt[r]--;
      if (bus.flush_e && m_last_vld) m_cnt[m_last_dst] = 0;
      if (ld) begin
        m_cnt[int'(bus.dst_d)] = int'(bus.lat_d);
        m_last_dst = int'(bus.dst_d);
      end
      m_last_vld = ld;
    end
    if (s && m_scnt < 64'hFFFF_FFFF) m_scnt++;
    @(negedge clk);
  endtask

  task automatic issue_w(input int dst, input int lat);
    idle();
    bus.valid_d = 1'b1;
    bus.wr_d    = 1'b1;
    bus.dst_d   = AW'(dst);
    bus.lat_d   = LATW'(lat);
    step();
  endtask

  // Present a reader of src until it issues; n = stall cycles seen.
  task automatic dep_until_issue(input int src, output int n);
    idle();
    bus.valid_d  = 1'b1;
    bus.use_rs_d = 1'b1;
    bus.rs_d     = AW'(src);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!obs_stall) return;
      n++;
    end
    chk("issue_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int     n;
    longint c0;

    idle();
    m_reset();
    // Reset state: decode reading any register must not stall.
    @(negedge clk);
    bus.valid_d = 1'b1; bus.use_rs_d = 1'b1; bus.rs_d = AW'(3);
    #1;
    chk("rst_stall", 64'(bus.stall_d),   64'd0);
    chk("rst_cnt",   64'(bus.stall_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    idle();

    // Load-use: one stall cycle, then M-stage forward.
    issue_w(8, 1);
    dep_until_issue(8, n);
    chk("loaduse_stalls", 64'(n), 64'd1);
    idle();
    bus.rs_e = AW'(8); bus.wreg_m = AW'(8); bus.regwrite_m = 1'b1;
    step();
    chk("loaduse_fwd", 64'(bus.fwd_a_e), 64'(FWD_M));

    // Multicycle producer.
    c0 = m_scnt;
    issue_w(9, 4);
    dep_until_issue(9, n);
    chk("mul_stalls", 64'(n), 64'd4);
    chk("mul_cnt", 64'(bus.stall_cnt), 64'(c0 + 4));

    // Hold freezes the countdown.
    issue_w(10, 3);
    idle();
    bus.valid_d = 1'b1; bus.use_rs_d = 1'b1; bus.rs_d = AW'(10); bus.hold = 1'b1;
    repeat (5) step();
    chk("hold_stall", 64'(obs_stall), 64'd1);
    dep_until_issue(10, n);
    chk("hold_after", 64'(n), 64'd3);

    // Flush releases the entry loaded last cycle.
    issue_w(11, 5);
    idle();
    bus.flush_e = 1'b1;
    step();
    dep_until_issue(11, n);
    chk("flush_free", 64'(n), 64'd0);

    // Forwarding priority.
    idle();
    bus.rs_e = AW'(4); bus.rt_e = AW'(4);
    bus.wreg_m = AW'(4); bus.wreg_w = AW'(4);
    bus.regwrite_m = 1'b1; bus.regwrite_w = 1'b1;
    step();
    chk("fwd_prio", 64'(bus.fwd_a_e), 64'(FWD_M));
    bus.rs_e = '0;
    bus.regwrite_m = 1'b0;
    step();
    chk("fwd_r0", 64'(bus.fwd_a_e), 64'(FWD_RF));
    chk("fwd_w",  64'(bus.fwd_b_e), 64'(FWD_W));

    // Reset mid-countdown discards pending latency and the stall count.
    issue_w(12, 6);
    idle();
    bus.valid_d = 1'b1; bus.use_rs_d = 1'b1; bus.rs_d = AW'(12);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_stall", 64'(bus.stall_d),   64'd0);
    chk("rst_mid_cnt",   64'(bus.stall_cnt), 64'd0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("rst_r12_free", 64'(obs_stall), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bus.valid_d    = ($urandom_range(0, 9) < 8);
      bus.rs_d       = AW'($urandom_range(0, 7));
      bus.rt_d       = AW'($urandom_range(0, 7));
      bus.use_rs_d   = 1'($urandom_range(0, 1));
      bus.use_rt_d   = 1'($urandom_range(0, 1));
      bus.dst_d      = AW'($urandom_range(0, 7));
      bus.wr_d       = 1'($urandom_range(0, 1));
      bus.lat_d      = LATW'($urandom_range(0, 7));
      bus.hold       = ($urandom_range(0, 7) == 0);
      bus.flush_e    = ($urandom_range(0, 9) == 0);
      bus.rs_e       = AW'($urandom_range(0, 7));
      bus.rt_e       = AW'($urandom_range(0, 7));
      bus.wreg_m     = AW'($urandom_range(0, 7));
      bus.regwrite_m = 1'($urandom_range(0, 1));
      bus.wreg_w     = AW'($urandom_range(0, 7));
      bus.regwrite_w = 1'($urandom_range(0, 1));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_hazard_sb.md
MIPS_HAZARD_SB -- requirements
Module: mips_hazard_sb

Interface
REQ-001 SHALL have parameter NREG, default 32: architectural register count.
REQ-002 SHALL have parameter AW, default 5: register-index width, equal to clog2(NREG).
REQ-003 SHALL have parameter LATW, default 3: latency-field width; maximum producer latency is 2^LATW-1.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports rs_d and rt_d, input, AW each: decode-stage source indices.
REQ-007 SHALL have ports use_rs_d and use_rt_d, input, 1 each: the decode instruction reads that source.
REQ-008 SHALL have port dst_d, input, AW: decode-stage destination index.
REQ-009 SHALL have port wr_d, input, 1: the decode instruction writes dst_d.
REQ-010 SHALL have port lat_d, input, LATW: cycles before the result is forwardable; 0 means ALU-class.
REQ-011 SHALL have port valid_d, input, 1: the decode slot holds a real instruction.
REQ-012 SHALL have port hold, input, 1: global pipeline freeze, e.g. memory wait.
REQ-013 SHALL have port flush_e, input, 1: cancel the instruction currently in E.
REQ-014 SHALL have ports rs_e and rt_e, input, AW each: execute-stage sources.
REQ-015 SHALL have ports wreg_m and regwrite_m, input, AW and 1: M-stage writeback target.
REQ-016 SHALL have ports wreg_w and regwrite_w, input, AW and 1: W-stage writeback target.
REQ-017 SHALL have port stall_d, output, 1: hold F/D and inject a bubble into E.
REQ-018 SHALL have ports fwd_a_e and fwd_b_e, output, 2 each: 00 regfile, 01 W, 10 M.
REQ-019 SHALL have port stall_cnt, output, 32: saturating count of stall_d cycles.

Function
REQ-020 SHALL keep one LATW-bit countdown per register; register i is busy iff count[i]!=0.
REQ-021 SHALL hold count[0] at 0 permanently; register 0 is never busy and never forwarded.
REQ-022 SHALL compute stall_d combinationally as valid_d & ((use_rs_d & busy(rs_d)) | (use_rt_d & busy(rt_d)) | (wr_d & busy(dst_d))), the last term being the WAW check.
REQ-023 SHALL define issue as valid_d & ~stall_d & ~hold.
REQ-024 SHALL load count[dst_d] with lat_d on an issue with wr_d=1, dst_d!=0 and lat_d!=0.
REQ-025 SHALL leave the scoreboard unchanged on an issue with lat_d=0.
REQ-026 SHALL decrement every nonzero count by 1 per cycle while hold=0, saturating at 0.
REQ-027 SHALL freeze all counts while hold=1; stall_d stays combinationally valid during hold.
REQ-028 SHALL NOT decrement a count in the cycle it is loaded; the loaded value is exactly lat_d.
REQ-029 SHALL register the index of the last-cycle issue that loaded an entry (last_dst, last_vld).
REQ-030 SHALL clear count[last_dst] on flush_e=1 with last_vld=1, overriding the decrement.
REQ-031 SHALL treat flush_e with last_vld=0 as a no-op on the scoreboard.
REQ-032 SHALL clear last_vld on any cycle without a loading issue; hold keeps last_vld unchanged.
REQ-033 SHALL set fwd_a_e=10 when regwrite_m & wreg_m!=0 & wreg_m==rs_e.
REQ-034 SHALL otherwise set fwd_a_e=01 when regwrite_w & wreg_w!=0 & wreg_w==rs_e, and 00 in all other cases; fwd_b_e follows the same rules using rt_e.
REQ-035 SHALL give M priority over W when both match.
REQ-036 SHALL increment stall_cnt on each cycle with stall_d=1, saturating at 0xFFFFFFFF.

Reset
REQ-037 SHALL, on reset low, asynchronously clear all counts, last_dst, last_vld and stall_cnt.
REQ-038 SHALL drive stall_d=0 while in reset; fwd outputs remain purely combinational.
REQ-039 SHALL, when reset asserts mid-countdown, discard all pending latencies, with no issue recorded until reset releases.

Structure
REQ-040 SHALL place the fwd select encodings (FWD_RF, FWD_W, FWD_M) and default LATW in the shared package mips_pkg.
REQ-041 SHALL implement forwarding via one sub-module, mips_fwd_sel, instantiated twice (A and B).
REQ-042 SHALL be scalable through its parameters with no hard-coded 32 outside the defaults.

Verification
REQ-043 SHALL verify load-use: issue load to r8 with lat_d=1, next cycle use_rs_d with rs_d=8 -> stall_d=1 for exactly 1 cycle, then issue, fwd_a_e=10.
REQ-044 SHALL verify multicycle: mul to r9 with lat_d=4, dependent follows -> stall_d high 4 cycles, stall_cnt +4.
REQ-045 SHALL verify hold: lat_d=3 on r10, hold=1 for 5 cycles after issue -> count[10] stays 3, stall on r10 persists 3 cycles after hold drops.
REQ-046 SHALL verify flush: lat_d=5 on r11, flush_e next cycle -> r11 free, dependent issues with no stall.
REQ-047 SHALL verify forwarding priority: wreg_m=wreg_w=rs_e=4 with both regwrites set -> fwd_a_e=10; rs_e=0 -> 00.
REQ-048 SHALL verify reset: assert reset low with r12 count=6 -> next decode reading r12 sees stall_d=0, stall_cnt=0.
